// File: rtl/idct_pkg.sv
// Shared types, defaults and constant helpers for the 8-point 1-D IDCT.
// Provides the cosine ROM generator idct_coe(), saturate() and sample type.
package idct_pkg;

    localparam int DATA_WIDTH_DEF = 10;
    localparam int COE_WIDTH_DEF  = 12;

    typedef logic signed [DATA_WIDTH_DEF-1:0] idct_sample_t;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } drain_st_t;

    // cos(m*pi/16) in Q2.30, m = 0..8
    function automatic longint cos_q30(input int m);
        longint v;
        case (m)
            0:       v = 64'sd1073741824;
            1:       v = 64'sd1053110176;
            2:       v = 64'sd992008094;
            3:       v = 64'sd892783698;
            4:       v = 64'sd759250125;
            5:       v = 64'sd596538995;
            6:       v = 64'sd410903207;
            7:       v = 64'sd209476638;
            default: v = 64'sd0;
        endcase
        return v;
    endfunction

    // round(c(k)*cos((2n+1)k*pi/16) * 2^(cw-1)), symmetric rounding.
    // c(0)*cos(0) = cos(pi/4), so the DC column reuses entry 4.
    function automatic int idct_coe(input int n, input int k,
                                    input int cw = COE_WIDTH_DEF);
        int     m;
        bit     neg;
        longint mag;
        longint half;
        neg = 1'b0;
        if (k == 0) begin
            m = 4;
        end else begin
            m = ((2 * n + 1) * k) % 32;
        end
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        mag  = cos_q30(m);
        half = 64'sd1 <<< (30 - cw);
        mag  = (mag + half) >>> (31 - cw);
        return neg ? -int'(mag) : int'(mag);
    endfunction

    function automatic longint saturate(input longint v, input int dw);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        else if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/idct_mac_lane.sv
// One IDCT output lane: ROM column lookup, multiply, accumulate-with-load.
// Ports: k_i coefficient index, x_i coefficient, en_i accept, sum_o next acc.
module idct_mac_lane
    import idct_pkg::*;
#(
    parameter int N          = 0,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int COE_WIDTH  = COE_WIDTH_DEF,
    parameter int ACC_WIDTH  = DATA_WIDTH_DEF + COE_WIDTH_DEF + 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2:0]                   k_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic                         en_i,
    output logic signed [ACC_WIDTH-1:0]  sum_o
);

    localparam int PW = DATA_WIDTH + COE_WIDTH;

    logic signed [COE_WIDTH-1:0] rom [8];
    logic signed [COE_WIDTH-1:0] coe;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;

    for (genvar k = 0; k < 8; k++) begin : g_rom
        assign rom[k] = COE_WIDTH'(idct_coe(N, k, COE_WIDTH));
    end

    assign coe  = rom[k_i];
    assign prod = PW'(x_i) * PW'(coe);

    // k==0 loads instead of adding, so blocks need no clear cycle
    always_comb begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        if (k_i == 3'd0) acc_d = ACC_WIDTH'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    // includes the current product so the top can load x[7]'s block at once
    assign sum_o = acc_d;

endmodule

// File: rtl/idct_1d_8pt.sv
// Streaming 8-point 1-D IDCT: serial X[0..7] in, serial x[0..7] out.
// Ports: in_data/in_valid in, out_data/out_valid/out_last out.
// IDCT_SOB_EN adds in_sob (force k=0) and sync_err (partial block dropped).
module idct_1d_8pt
    import idct_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int COE_WIDTH  = COE_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         out_last
`ifdef IDCT_SOB_EN
   ,input  logic                         in_sob,
    output logic                         sync_err
`endif
);

    localparam int ACC_WIDTH = DATA_WIDTH + COE_WIDTH + 3;

    localparam logic signed [ACC_WIDTH-1:0] RND =
        {{(ACC_WIDTH-COE_WIDTH){1'b0}}, 1'b1, {(COE_WIDTH-1){1'b0}}};

    logic [2:0] k_q;
    logic [2:0] k_d;
    logic [2:0] k_eff;
    logic       sob_hit;
    logic       blk_done;

`ifdef IDCT_SOB_EN
    logic err_q;
    logic err_d;

    assign sob_hit = in_valid & in_sob;
    assign err_d   = sob_hit & (k_q != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sync_err = err_q;
`else
    assign sob_hit = 1'b0;
`endif

    assign k_eff    = sob_hit ? 3'd0 : k_q;
    assign k_d      = in_valid ? k_eff + 3'd1 : k_q;
    assign blk_done = in_valid & (k_eff == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= 3'd0;
        end else begin
            k_q <= k_d;
        end
    end

    logic signed [ACC_WIDTH-1:0]  sum [8];
    logic signed [DATA_WIDTH-1:0] smp [8];

    for (genvar n = 0; n < 8; n++) begin : g_lane
        logic signed [ACC_WIDTH-1:0] rnd;

        idct_mac_lane #(
            .N          (n),
            .DATA_WIDTH (DATA_WIDTH),
            .COE_WIDTH  (COE_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .k_i   (k_eff),
            .x_i   (in_data),
            .en_i  (in_valid),
            .sum_o (sum[n])
        );

        assign rnd    = (sum[n] + RND) >>> COE_WIDTH;
        assign smp[n] = DATA_WIDTH'(saturate(64'(rnd), DATA_WIDTH));
    end

    drain_st_t state_q;
    drain_st_t state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic signed [DATA_WIDTH-1:0] sh_q [8];
    logic signed [DATA_WIDTH-1:0] sh_d [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            for (int i = 0; i < 8; i++) sh_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 8; i++) sh_q[i] <= sh_d[i];
        end
    end

    // a new block may load on the same edge that retires x[7]
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (blk_done) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 3'd0;
                end
            end
            ST_DRAIN: begin
                if (blk_done) begin
                    cnt_d = 3'd0;
                end else if (cnt_q == 3'd7) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 8; i++) sh_d[i] = sh_q[i];
        if (blk_done) begin
            for (int i = 0; i < 8; i++) sh_d[i] = smp[i];
        end else if (state_q == ST_DRAIN) begin
            for (int i = 0; i < 7; i++) sh_d[i] = sh_q[i+1];
            sh_d[7] = '0;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_DRAIN);
        out_last  = (state_q == ST_DRAIN) && (cnt_q == 3'd7);
        out_data  = sh_q[0];
    end

endmodule

// File: tb/tb_idct_1d_8pt.sv
// Self-checking bench for idct_1d_8pt against a real-valued IDCT model.
// Checks values (+/-1 LSB), exact output cycles, out_last and reset behaviour.
`timescale 1ns/1ps
module tb_idct_1d_8pt;
    import idct_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    idct_sample_t in_data = '0;
    logic         in_valid = 1'b0;
    idct_sample_t out_data;
    logic         out_valid;
    logic         out_last;
`ifdef IDCT_SOB_EN
    logic         in_sob = 1'b0;
    logic         sync_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int obs_d[$];
    int obs_c[$];
    bit obs_l[$];
    int exp_d[$];
    int exp_c[$];
    bit exp_l[$];

    idct_1d_8pt #(
        .DATA_WIDTH (10),
        .COE_WIDTH  (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
`ifdef IDCT_SOB_EN
       ,.in_sob    (in_sob),
        .sync_err  (sync_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_d.push_back(int'(out_data));
            obs_c.push_back(cyc);
            obs_l.push_back(out_last);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp);
        int d;
        d = obs - exp;
        n_assert++;
        assert ((d >= -1 && d <= 1) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d +/-1", tag, obs, exp);
        end
    endtask

    function automatic int ref_x(input int X[8], input int n);
        real s;
        real c;
        int  r;
        s = 0.0;
        for (int k = 0; k < 8; k++) begin
            c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            s = s + c / 2.0 * X[k] *
                $cos((2 * n + 1) * k * 3.14159265358979 / 16.0);
        end
        r = $rtoi($floor(s + 0.5));
        if (r > 511) r = 511;
        if (r < -512) r = -512;
        return r;
    endfunction

    task automatic send(input int X[8], input int gaps[8], input bit sob);
        int t;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b0;
            repeat (gaps[k]) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = idct_sample_t'(X[k]);
`ifdef IDCT_SOB_EN
            in_sob   = sob && (k == 0);
`endif
            @(posedge clk);
            #1;
`ifdef IDCT_SOB_EN
            if (sob && k == 0) chk("sync_err_pulse", int'(sync_err), 1);
            if (sob && k == 1) chk("sync_err_clear", int'(sync_err), 0);
            in_sob = 1'b0;
`endif
        end
        in_valid = 1'b0;
        t = cyc;
        for (int n = 0; n < 8; n++) begin
            exp_d.push_back(ref_x(X, n));
            exp_c.push_back(t + n);
            exp_l.push_back(n == 7);
        end
    endtask

    task automatic flush(input string tag);
        int m;
        repeat (12) @(posedge clk);
        #1;
        chk({tag, "_count"}, obs_d.size(), exp_d.size());
        m = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
        for (int i = 0; i < m; i++) begin
            chk_tol($sformatf("%s_x%0d", tag, i), obs_d[i], exp_d[i]);
            chk($sformatf("%s_cyc%0d", tag, i), obs_c[i], exp_c[i]);
            chk($sformatf("%s_last%0d", tag, i), int'(obs_l[i]), int'(exp_l[i]));
        end
        obs_d.delete();
        obs_c.delete();
        obs_l.delete();
        exp_d.delete();
        exp_c.delete();
        exp_l.delete();
    endtask

    initial begin
        int X[8];
        int nog[8];
        int gp[8];
        int r[8];

        nog = '{0, 0, 0, 0, 0, 0, 0, 0};

        // reset state
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_data", int'(out_data), 0);
`ifdef IDCT_SOB_EN
        chk("rst_sync_err", int'(sync_err), 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DC block
        X = '{64, 0, 0, 0, 0, 0, 0, 0};
        send(X, nog, 1'b0);
        chk("dc_ref", ref_x(X, 3), 23);
        flush("dc");

        // AC1 block
        X = '{0, 100, 0, 0, 0, 0, 0, 0};
        send(X, nog, 1'b0);
        chk("ac1_ref", ref_x(X, 7), -49);
        flush("ac1");

        // DC block with input gaps, output stays contiguous
        X  = '{64, 0, 0, 0, 0, 0, 0, 0};
        gp = '{0, 2, 0, 2, 1, 0, 3, 2};
        send(X, gp, 1'b0);
        flush("gaps");

        // saturation
        X = '{511, 511, 511, 511, 511, 511, 511, 511};
        send(X, nog, 1'b0);
        chk("sat_ref", ref_x(X, 0), 511);
        flush("sat");

        // back-to-back blocks
        X = '{64, 0, 0, 0, 0, 0, 0, 0};
        send(X, nog, 1'b0);
        X = '{0, 100, 0, 0, 0, 0, 0, 0};
        send(X, nog, 1'b0);
        flush("b2b");

        // reset after X[3]
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = idct_sample_t'(100 + k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_out", obs_d.size(), 0);
        for (int k = 0; k < 8; k++) r[k] = int'($urandom_range(0, 1022)) - 511;
        send(r, nog, 1'b0);
        flush("post_rst");

        // reset mid-drain keeps only x[0]
        X = '{0, 100, 0, 0, 0, 0, 0, 0};
        send(X, nog, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        while (exp_d.size() > 1) begin
            void'(exp_d.pop_back());
            void'(exp_c.pop_back());
            void'(exp_l.pop_back());
        end
        exp_l[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush("drain_rst");

        // random blocks, random gaps, back-to-back where gaps are 0
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 8; k++) begin
                r[k]  = int'($urandom_range(0, 1022)) - 511;
                gp[k] = int'($urandom_range(0, 1));
            end
            send(r, gp, 1'b0);
        end
        flush("rand");

`ifdef IDCT_SOB_EN
        // in_sob at k=5 drops the partial block
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = idct_sample_t'(300 - k);
            @(posedge clk);
            #1;
        end
        X = '{0, 100, 0, 0, 0, 0, 0, 0};
        send(X, nog, 1'b1);
        flush("sob");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
